pixel_word_packer: RTL



---
 rtl/pix_pkg.sv | 16 +
 rtl/pix_word_fifo.sv | 55 +++++
 rtl/pixel_word_packer.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pix_pkg.sv
// rtl/pix_pkg.sv - shared pixel pipeline constants and data_proc mode encoding
package pix_pkg;

    localparam int PIX_W        = 8;
    localparam int FRAME_DIM    = 32;
    localparam int FRAME_PIX    = FRAME_DIM * FRAME_DIM;
    localparam int PIX_PER_WORD = 4;
    localparam int WORD_W       = PIX_W * PIX_PER_WORD;

    // data_proc processing modes
    localparam logic [1:0] MODE_BYPASS   = 2'd0;
    localparam logic [1:0] MODE_INVERT   = 2'd1;
    localparam logic [1:0] MODE_CONV     = 2'd2;
    localparam logic [1:0] MODE_RESERVED = 2'd3;

endpackage

// File: rtl/pix_word_fifo.sv
// rtl/pix_word_fifo.sv - synchronous first-word-fall-through word buffer
module pix_word_fifo
    import pix_pkg::*;
#(
    parameter int W     = pix_pkg::WORD_W + 1,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Head reads as zero when empty so the outputs stay clean after reset.
    assign head    = empty ? '0 : mem[rd_ptr];

    // Storage array; contents are don't-care until a push marks them valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keep count.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/pixel_word_packer.sv
// rtl/pixel_word_packer.sv - packs pixels into 32-bit words with frame tagging
module pixel_word_packer
    import pix_pkg::*;
#(
    parameter int PIX_W        = pix_pkg::PIX_W,
    parameter int PIX_PER_WORD = pix_pkg::PIX_PER_WORD,
    parameter int FRAME_PIX    = pix_pkg::FRAME_PIX,
    parameter int OBUF_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PIX_W-1:0]              pixel_in,
    input  logic                          VALID_IN,
    output logic                          READY_OUT,
    input  logic                          flush,
    output logic [PIX_W*PIX_PER_WORD-1:0] word_out,
    output logic                          word_last,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic                          frame_done,
    output logic [15:0]                   frame_count
);

    localparam int WW     = PIX_W * PIX_PER_WORD;
    localparam int LANE_W = $clog2(PIX_PER_WORD);
    localparam int CNT_W  = $clog2(FRAME_PIX);

    typedef struct packed {
        logic          last;
        logic [WW-1:0] data;
    } entry_t;

    logic [LANE_W-1:0] lane;
    logic [CNT_W-1:0]  pix_cnt;
    logic [WW-1:0]     word_reg;
    logic [WW-1:0]     word_next;
    logic              flush_pend;
    logic              accept;
    logic              lane_last;
    logic              flush_req;
    logic              partial;
    logic              push;
    logic              pop;
    logic              obuf_full;
    logic              obuf_empty;
    entry_t            push_entry;
    entry_t            head_entry;

    assign lane_last = (lane == LANE_W'(PIX_PER_WORD - 1));
    // A pending flush freezes intake so the pad word closes the frame cleanly.
    assign READY_OUT = !flush_pend && (!lane_last || !obuf_full);
    assign accept    = VALID_IN && READY_OUT;
    assign flush_req = flush || flush_pend;
    assign partial   = (lane != '0) || accept;
    assign pop       = word_valid && word_ready;

    // Merge the incoming pixel into its lane and decide whether a word leaves.
    always_comb begin
        word_next = word_reg;
        push      = 1'b0;
        if (accept) begin
            word_next[lane*PIX_W +: PIX_W] = pixel_in;
        end
        push_entry.data = word_next;
        push_entry.last = 1'b0;
        if (flush_req && partial && !obuf_full) begin
            push            = 1'b1;
            push_entry.last = 1'b1;
        end else if (accept && lane_last) begin
            push            = 1'b1;
            push_entry.last = (pix_cnt == CNT_W'(FRAME_PIX - 1));
        end
    end

    // Lane, pixel counter, word staging and flush-pending state.
    always_ff @(posedge clk) begin
        if (rst) begin
            lane       <= '0;
            pix_cnt    <= '0;
            word_reg   <= '0;
            flush_pend <= 1'b0;
        end else if (flush_req && !partial) begin
            pix_cnt    <= '0;
            flush_pend <= 1'b0;
        end else if (flush_req && !obuf_full) begin
            lane       <= '0;
            pix_cnt    <= '0;
            word_reg   <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (flush_req) flush_pend <= 1'b1;
            if (accept) begin
                pix_cnt <= (pix_cnt == CNT_W'(FRAME_PIX - 1)) ? '0 : pix_cnt + 1'b1;
                if (lane_last) begin
                    lane     <= '0;
                    word_reg <= '0;
                end else begin
                    lane     <= lane + 1'b1;
                    word_reg <= word_next;
                end
            end
        end
    end

    // Frame completion is signalled when the last word actually leaves.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= pop && head_entry.last;
            if (pop && head_entry.last) frame_count <= frame_count + 1'b1;
        end
    end

    pix_word_fifo #(
        .W     ($bits(entry_t)),
        .DEPTH (OBUF_DEPTH)
    ) u_obuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head_entry),
        .full      (obuf_full),
        .empty     (obuf_empty)
    );

    assign word_valid = !obuf_empty;
    assign word_out   = head_entry.data;
    assign word_last  = head_entry.last;

endmodule
